dca_matrix_lsu_txn_gen: RTL and testbench
=========================================

Name: dca_matrix_lsu_txn_gen

Overview:
- Upstream stage of the DCA matrix LSU read-request issuer.
- Accepts one matrix load/store instruction and walks the matrix row by row.
- Splits each row into AXI-legal INCR bursts: max burst length, never crossing a 4 KB boundary.
- Emits one transaction-info word per burst over a valid/ready handshake. The downstream issuer turns each word into an LPIXM AXI request.

Parameters:
- BW_AXI_ADDR, 32, AXI address width.
- BW_AXI_DATA, 32, AXI data width (power of 2, ≥32); BYTES = BW_AXI_DATA/8.
- MAX_BURST_LEN, 16, maximum beats per burst (1..256).
- BW_NUM, 16, width of the row-count and column-count fields.
- BW_BITADDR, BW_AXI_ADDR+3, width of the bit address field in transaction info.

Ports:
- clk  in  1  clock
- rstnn  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort; returns FSM to IDLE
- inst_valid  in  1  instruction present
- inst_ready  out  1  instruction accepted this cycle
- inst_addr  in  BW_AXI_ADDR  matrix base byte address; must be BYTES-aligned
- inst_stride  in  BW_AXI_ADDR  row stride in bytes; must be BYTES-aligned
- inst_num_row_m1  in  BW_NUM  rows-1
- inst_num_col_m1  in  BW_NUM  columns-1
- inst_esize_log2  in  2  element size log2 bytes (0..3)
- txn_valid  out  1  transaction info valid
- txn_ready  in  1  downstream accepts
- txn_info  out  BW_BITADDR+10  {last_of_inst, last_of_row, alen[7:0], bitaddr}
- busy  out  1  instruction in progress
- done  out  1  one-cycle pulse after the final txn is accepted
- align_err  out  1  sticky; set when an accepted instruction has a misaligned addr or stride

Behaviour:
- Reset values: inst_ready=0, txn_valid=0, txn_info=0, busy=0, done=0, align_err=0, all counters 0.
- Clock and reset: single clock clk; rstnn is asynchronous assert, active-low, and clears every register.
- FSM states: IDLE, CALC, ISSUE, DONE.
- IDLE:
  - inst_ready=1.
  - On inst_valid, latch all fields.
  - row_addr=cur_addr=inst_addr, row_cnt=0.
  - rem_beats = ceil(((num_col_m1+1)<<esize)/BYTES); compute in BW_NUM+4 bits, no overflow.
  - Go to CALC.
  - Misaligned addr or stride: set align_err, drop the low log2(BYTES) address bits, and process normally.
- CALC (one cycle):
  - to4k = (4096 - cur_addr[11:0])/BYTES.
  - beats = min(rem_beats, MAX_BURST_LEN, to4k); alen = beats-1.
  - last_of_row = (beats==rem_beats).
  - last_of_inst = last_of_row & (row_cnt==num_row_m1).
  - Register txn_info with bitaddr = cur_addr<<3. Go to ISSUE.
- ISSUE:
  - txn_valid=1; txn_info is held stable until txn_ready.
  - On handshake: cur_addr += beats*BYTES; rem_beats -= beats.
  - If last_of_inst: go to DONE.
  - Else if last_of_row: row_addr += stride, cur_addr = new row_addr, row_cnt++, reload rem_beats, go to CALC.
  - Else: go to CALC.
- DONE: done=1 for one cycle, then IDLE.
- Throughput: CALC→ISSUE costs one bubble per burst. Minimum 2 cycles per txn; peak rate is not required.
- busy=1 in CALC, ISSUE and DONE.
- Address arithmetic wraps modulo 2^BW_AXI_ADDR; no overflow detection.
- clear: highest priority in any state. Drops txn_valid in the same cycle and does not pulse done. align_err is held.
- A new instruction is accepted in IDLE only; inst_valid is ignored elsewhere.
- Reset mid-operation: all state is lost immediately; txn_valid drops asynchronously.

Decomposition:
- Shared package/header (dca_lsu_txn_gen defines):
  - txn_info field widths and bit positions.
  - State encodings.
  - 4 KB boundary constant (12).
- Header rule: field ordering of txn_info must match the downstream issuer's unpacking.
- Optional sub-module dca_lsu_burst_calc: combinational min(rem, MAX, to4k) plus last flags, for reuse by the write-side generator.

Test Plan:
- Single burst, 32-bit bus: addr=0x1000, 1 row, 8 cols, esize=2, txn_ready=1 → one txn: bitaddr=0x8000, alen=7, last_of_row=1, last_of_inst=1; done pulses 1 cycle later.
- Burst split: 1 row, 40 cols, esize=2, MAX=16 → alen 15,15,7 at addrs 0x1000, 0x1040, 0x1080; only the third has last flags set.
- 4 KB crossing: addr=0x1FF0, 8 words → alen=3 at 0x1FF0, then alen=3 at 0x2000; the second is last.
- Multi-row with stride: 3 rows, 4 cols, esize=2, stride=0x100, addr=0x0 → three txns at bitaddr 0x0, 0x800, 0x1000, each alen=3; last_of_inst only on the third.
- Backpressure: hold txn_ready=0 for 5 cycles in ISSUE → txn_valid stays 1 and txn_info stays constant; on release, the handshake completes and the next txn follows.
- Abort and misalignment:
  - Assert clear during the second burst → txn_valid=0 next cycle, state IDLE, no done.
  - Issue addr=0x1002 → align_err=1, and the first bitaddr is 0x8000.

Source files
------------

// File: rtl/dca_matrix_lsu_txn_gen_pkg.sv
// Shared definitions for the matrix LSU transaction generator and its downstream issuer.
// txn_info layout (LSB first): bitaddr, alen[7:0], last_of_row, last_of_inst.
package dca_matrix_lsu_txn_gen_pkg;

  localparam int BOUNDARY_4K_LOG2 = 12;
  localparam int TXN_ALEN_W       = 8;
  localparam int TXN_FLAG_W       = 2;
  localparam int TXN_BITADDR_LSB  = 0;

  // Bit positions depend on the bitaddr width, which is a parameter of the block.
  function automatic int txn_alen_lsb(input int bw_bitaddr);
    return bw_bitaddr;
  endfunction

  function automatic int txn_lor_bit(input int bw_bitaddr);
    return bw_bitaddr + TXN_ALEN_W;
  endfunction

  function automatic int txn_loi_bit(input int bw_bitaddr);
    return bw_bitaddr + TXN_ALEN_W + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } txn_state_e;

endpackage

// File: rtl/dca_matrix_lsu_txn_gen_burst_calc.sv
// Combinational burst sizing: min(remaining beats, max burst, beats to 4 KB edge) plus last flags.
// Shared between the read- and write-side transaction generators.
module dca_matrix_lsu_txn_gen_burst_calc
  import dca_matrix_lsu_txn_gen_pkg::*;
#(
  parameter int BW_AXI_DATA   = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int BW_NUM        = 16,
  parameter int BW_REM        = BW_NUM + 4
) (
  input  logic [BW_REM-1:0]           rem_beats,
  input  logic [BOUNDARY_4K_LOG2-1:0] addr_lo,
  input  logic [BW_NUM-1:0]           row_cnt,
  input  logic [BW_NUM-1:0]           num_row_m1,
  output logic [8:0]                  beats,
  output logic [TXN_ALEN_W-1:0]       alen,
  output logic                        last_of_row,
  output logic                        last_of_inst
);

  localparam int BYTES = BW_AXI_DATA / 8;
  localparam int BL    = $clog2(BYTES);
  localparam logic [BW_REM-1:0] MAX_W = BW_REM'(MAX_BURST_LEN);

  logic [BOUNDARY_4K_LOG2:0] to4k_bytes;
  logic [BW_REM-1:0]         lim;
  logic [BW_REM-1:0]         beats_w;
  logic [BW_REM-1:0]         alen_w;
  logic                      unused_hi;

  always_comb begin
    to4k_bytes = (BOUNDARY_4K_LOG2+1)'(1 << BOUNDARY_4K_LOG2) - {1'b0, addr_lo};
    lim        = BW_REM'(to4k_bytes >> BL);
    if (lim > MAX_W) lim = MAX_W;
    beats_w    = (rem_beats < lim) ? rem_beats : lim;
    alen_w     = beats_w - BW_REM'(1);
  end

  // beats is 1..256, so the upper bits are always zero.
  assign beats        = beats_w[8:0];
  assign alen         = alen_w[TXN_ALEN_W-1:0];
  assign last_of_row  = (beats_w == rem_beats);
  assign last_of_inst = last_of_row & (row_cnt == num_row_m1);
  assign unused_hi    = ^{beats_w[BW_REM-1:9], alen_w[BW_REM-1:TXN_ALEN_W]};

endmodule

// File: rtl/dca_matrix_lsu_txn_gen.sv
// Matrix LSU transaction generator: walks a matrix row by row and emits one
// AXI-legal INCR burst descriptor per handshake to the downstream issuer.
module dca_matrix_lsu_txn_gen
  import dca_matrix_lsu_txn_gen_pkg::*;
#(
  parameter int BW_AXI_ADDR   = 32,
  parameter int BW_AXI_DATA   = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int BW_NUM        = 16,
  parameter int BW_BITADDR    = BW_AXI_ADDR + 3
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic [BW_AXI_ADDR-1:0]   inst_addr,
  input  logic [BW_AXI_ADDR-1:0]   inst_stride,
  input  logic [BW_NUM-1:0]        inst_num_row_m1,
  input  logic [BW_NUM-1:0]        inst_num_col_m1,
  input  logic [1:0]               inst_esize_log2,
  output logic                     txn_valid,
  input  logic                     txn_ready,
  output logic [BW_BITADDR+9:0]    txn_info,
  output logic                     busy,
  output logic                     done,
  output logic                     align_err
);

  localparam int BYTES   = BW_AXI_DATA / 8;
  localparam int BL      = $clog2(BYTES);
  localparam int BW_REM  = BW_NUM + 4;
  localparam int BW_INFO = BW_BITADDR + TXN_ALEN_W + TXN_FLAG_W;
  localparam int LOI_BIT = txn_loi_bit(BW_BITADDR);
  localparam logic [BW_AXI_ADDR-1:0] ADDR_MASK = ~BW_AXI_ADDR'(BYTES - 1);

  txn_state_e state, state_nxt;
  logic                   rdy_q;
  logic [BW_AXI_ADDR-1:0] row_addr, cur_addr, stride_q;
  logic [BW_NUM-1:0]      num_row_m1_q, row_cnt;
  logic [BW_REM-1:0]      row_beats, rem_beats;
  logic [8:0]             beats_q;
  logic [BW_INFO-1:0]     info_q;
  logic                   align_err_q;

  logic [BW_REM-1:0]      col_ext, row_bytes, row_beats_new;
  logic                   misaligned;
  logic [BW_AXI_ADDR-1:0] beat_bytes, next_row_addr;
  logic [8:0]             calc_beats;
  logic [TXN_ALEN_W-1:0]  calc_alen;
  logic                   calc_lor, calc_loi;
  logic                   inst_acc, calc_en, txn_hs;

  dca_matrix_lsu_txn_gen_burst_calc #(
    .BW_AXI_DATA  (BW_AXI_DATA),
    .MAX_BURST_LEN(MAX_BURST_LEN),
    .BW_NUM       (BW_NUM),
    .BW_REM       (BW_REM)
  ) u_burst_calc (
    .rem_beats   (rem_beats),
    .addr_lo     (cur_addr[BOUNDARY_4K_LOG2-1:0]),
    .row_cnt     (row_cnt),
    .num_row_m1  (num_row_m1_q),
    .beats       (calc_beats),
    .alen        (calc_alen),
    .last_of_row (calc_lor),
    .last_of_inst(calc_loi)
  );

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // clear overrides every state; txn_valid and done are gated so the abort is visible at once.
  always_comb begin
    state_nxt  = state;
    inst_ready = 1'b0;
    txn_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state != ST_IDLE);
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          inst_ready = rdy_q;
          if (inst_valid && rdy_q) state_nxt = ST_CALC;
        end
        ST_CALC: state_nxt = ST_ISSUE;
        ST_ISSUE: begin
          txn_valid = 1'b1;
          if (txn_ready) state_nxt = info_q[LOI_BIT] ? ST_DONE : ST_CALC;
        end
        ST_DONE: begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    col_ext       = BW_REM'(inst_num_col_m1) + BW_REM'(1);
    row_bytes     = col_ext << inst_esize_log2;
    row_beats_new = (row_bytes >> BL) + BW_REM'(|row_bytes[BL-1:0]);
    misaligned    = |{inst_addr[BL-1:0], inst_stride[BL-1:0]};
    beat_bytes    = BW_AXI_ADDR'(beats_q) << BL;
    next_row_addr = row_addr + stride_q;
  end

  assign inst_acc = inst_valid & inst_ready;
  assign calc_en  = (state == ST_CALC) & ~clear;
  assign txn_hs   = txn_valid & txn_ready;

  // inst_ready is registered so it reads 0 while reset is held and for the first cycle after.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      rdy_q        <= 1'b0;
      row_addr     <= '0;
      cur_addr     <= '0;
      stride_q     <= '0;
      num_row_m1_q <= '0;
      row_cnt      <= '0;
      row_beats    <= '0;
      rem_beats    <= '0;
      beats_q      <= '0;
      info_q       <= '0;
      align_err_q  <= 1'b0;
    end else begin
      rdy_q <= (state_nxt == ST_IDLE);
      if (inst_acc) begin
        row_addr     <= inst_addr & ADDR_MASK;
        cur_addr     <= inst_addr & ADDR_MASK;
        stride_q     <= inst_stride & ADDR_MASK;
        num_row_m1_q <= inst_num_row_m1;
        row_cnt      <= '0;
        row_beats    <= row_beats_new;
        rem_beats    <= row_beats_new;
        if (misaligned) align_err_q <= 1'b1;
      end
      if (calc_en) begin
        beats_q <= calc_beats;
        info_q  <= {calc_loi, calc_lor, calc_alen, cur_addr, 3'b000};
      end
      if (txn_hs) begin
        if (info_q[LOI_BIT-1]) begin
          row_addr  <= next_row_addr;
          cur_addr  <= next_row_addr;
          row_cnt   <= row_cnt + BW_NUM'(1);
          rem_beats <= row_beats;
        end else begin
          cur_addr  <= cur_addr + beat_bytes;
          rem_beats <= rem_beats - BW_REM'(beats_q);
        end
      end
    end
  end

  assign txn_info  = info_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_dca_matrix_lsu_txn_gen.sv
// Directed bench for the matrix LSU transaction generator with hand-computed txn words.
module tb_dca_matrix_lsu_txn_gen;
  localparam int AW  = 32;
  localparam int NW  = 16;
  localparam int BAW = AW + 3;
  localparam int IW  = BAW + 10;

  logic          clk = 1'b0;
  logic          rstnn, clear, inst_valid, inst_ready, txn_valid, txn_ready;
  logic          busy, done, align_err;
  logic [AW-1:0] inst_addr, inst_stride;
  logic [NW-1:0] inst_num_row_m1, inst_num_col_m1;
  logic [1:0]    inst_esize_log2;
  logic [IW-1:0] txn_info;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dca_matrix_lsu_txn_gen dut (
    .clk(clk), .rstnn(rstnn), .clear(clear),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_addr(inst_addr), .inst_stride(inst_stride),
    .inst_num_row_m1(inst_num_row_m1), .inst_num_col_m1(inst_num_col_m1),
    .inst_esize_log2(inst_esize_log2),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_info(txn_info),
    .busy(busy), .done(done), .align_err(align_err)
  );

  function automatic logic [IW-1:0] info(input bit loi, input bit lor, input int alen,
                                         input longint ba);
    return {loi, lor, 8'(alen), BAW'(ba)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] s,
                      input logic [NW-1:0] r, input logic [NW-1:0] c, input logic [1:0] e);
    int t = 0;
    while (!inst_ready && t < 20) begin step(); t++; end
    check("inst_ready_wait", 64'(inst_ready), 64'(1));
    inst_addr = a; inst_stride = s; inst_num_row_m1 = r; inst_num_col_m1 = c;
    inst_esize_log2 = e; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
  endtask

  task automatic wait_txn(input string tag);
    int t = 0;
    while (!txn_valid && t < 50) begin step(); t++; end
    check({tag, "_valid"}, 64'(txn_valid), 64'(1));
  endtask

  task automatic take(input string tag, input logic [IW-1:0] exp);
    wait_txn(tag);
    check(tag, 64'(txn_info), 64'(exp));
    txn_ready = 1'b1;
    step();
    txn_ready = 1'b0;
  endtask

  task automatic chk_done(input string tag);
    check({tag, "_done"}, 64'(done), 64'(1));
    step();
    check({tag, "_done_off"}, 64'(done), 64'(0));
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    rstnn = 1'b0; clear = 1'b0; inst_valid = 1'b0; txn_ready = 1'b0;
    inst_addr = '0; inst_stride = '0; inst_num_row_m1 = '0; inst_num_col_m1 = '0;
    inst_esize_log2 = '0;
    #12;
    check("rst_inst_ready", 64'(inst_ready), 64'(0));
    check("rst_txn_valid",  64'(txn_valid),  64'(0));
    check("rst_txn_info",   64'(txn_info),   64'(0));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_done",       64'(done),       64'(0));
    check("rst_align_err",  64'(align_err),  64'(0));
    @(negedge clk);
    rstnn = 1'b1;
    step();
    check("post_rst_ready", 64'(inst_ready), 64'(1));

    // single burst
    send(32'h1000, 32'h0, 16'd0, 16'd7, 2'd2);
    check("t1_busy", 64'(busy), 64'(1));
    take("t1_txn", info(1, 1, 7, 'h8000));
    chk_done("t1");

    // burst split with 5 cycles of backpressure on the first txn
    send(32'h1000, 32'h0, 16'd0, 16'd39, 2'd2);
    wait_txn("t2_bp");
    for (int i = 0; i < 5; i++) begin
      check("t2_bp_valid", 64'(txn_valid), 64'(1));
      check("t2_bp_info",  64'(txn_info),  64'(info(0, 0, 15, 'h8000)));
      step();
    end
    txn_ready = 1'b1;
    step();
    txn_ready = 1'b0;
    take("t2_txn1", info(0, 0, 15, 'h8200));
    take("t2_txn2", info(1, 1, 7,  'h8400));
    chk_done("t2");

    // 4 KB crossing
    send(32'h1FF0, 32'h0, 16'd0, 16'd7, 2'd2);
    take("t3_txn0", info(0, 0, 3, 'hFF80));
    take("t3_txn1", info(1, 1, 3, 'h10000));
    chk_done("t3");

    // multi-row with stride
    send(32'h0, 32'h100, 16'd2, 16'd3, 2'd2);
    take("t4_row0", info(0, 1, 3, 'h0));
    take("t4_row1", info(0, 1, 3, 'h800));
    take("t4_row2", info(1, 1, 3, 'h1000));
    chk_done("t4");

    // misaligned address: low bits dropped, sticky error
    check("t5_align_before", 64'(align_err), 64'(0));
    send(32'h1002, 32'h0, 16'd0, 16'd7, 2'd2);
    check("t5_align_err", 64'(align_err), 64'(1));
    take("t5_txn", info(1, 1, 7, 'h8000));
    chk_done("t5");

    // clear during the second burst
    send(32'h1000, 32'h0, 16'd0, 16'd39, 2'd2);
    take("t6_txn0", info(0, 0, 15, 'h8000));
    wait_txn("t6_txn1");
    check("t6_txn1", 64'(txn_info), 64'(info(0, 0, 15, 'h8200)));
    clear = 1'b1;
    #1;
    check("t6_clear_valid", 64'(txn_valid), 64'(0));
    step();
    clear = 1'b0;
    #1;
    check("t6_clear_done",  64'(done),       64'(0));
    check("t6_clear_busy",  64'(busy),       64'(0));
    check("t6_clear_ready", 64'(inst_ready), 64'(1));
    check("t6_align_held",  64'(align_err),  64'(1));
    step(3);
    check("t6_no_done", 64'(done), 64'(0));

    // engine still works after abort
    send(32'h2000, 32'h0, 16'd0, 16'd3, 2'd2);
    take("t7_txn", info(1, 1, 3, 'h10000));
    chk_done("t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
